// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the cpu
// data port and the host/loader port, with req/ack handshakes and cpu stall.
//
// state | meaning
// IDLE  | sample eligible requests, pick winner, latch its transaction
// ISSUE | drive the latched access onto the memory port (mem_en high)
// DONE  | ack the owner; on a read, mem_rdata is presented and captured
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  input  logic              host_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              owner_q;
  logic              last_grant_q;
  logic              we_q;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic cpu_elig;
  logic host_elig;
  logic grant;
  logic grant_host;
  logic rd_done;

  // Byte-lane bits and address bits above the memory window are dropped (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[ADDR_W-1:MEM_AW+2], cpu_addr[1:0],
                              host_addr[ADDR_W-1:MEM_AW+2], host_addr[1:0]};

  assign cpu_elig  = cpu_req & ~host_lock;
  assign host_elig = host_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_host = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_elig || host_elig) begin
          grant      = 1'b1;
          // On a tie the port that did not win last time goes first.
          grant_host = host_elig & (~cpu_elig | (last_grant_q == OWN_CPU));
          state_nxt  = ISSUE;
        end
      end
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_HOST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (grant) begin
      owner_q      <= grant_host;
      last_grant_q <= grant_host;
      we_q         <= grant_host ? host_we : cpu_we;
      addr_q       <= grant_host ? host_addr[MEM_AW+1:2] : cpu_addr[MEM_AW+1:2];
      wdata_q      <= grant_host ? host_wdata : cpu_wdata;
    end
  end

  assign rd_done = (state == DONE) && !we_q;

  // The memory answers during DONE; hold that word for the owner afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if (rd_done) begin
      if (owner_q == OWN_HOST) begin
        host_rdata_q <= mem_rdata;
      end else begin
        cpu_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu_ack   = (state == DONE) && (owner_q == OWN_CPU);
  assign host_ack  = (state == DONE) && (owner_q == OWN_HOST);
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Registered memory output is forwarded during DONE so rdata is valid with ack.
  assign cpu_rdata  = (rd_done && owner_q == OWN_CPU)  ? mem_rdata : cpu_rdata_q;
  assign host_rdata = (rd_done && owner_q == OWN_HOST) ? mem_rdata : host_rdata_q;

endmodule
